// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter with load, wrap/saturate, carry out and sticky wrap flag
// Ports: clk, rst (sync, active-high); en, up_dn, load, load_val, clr_flag in;
// count (registered), tc (combinational terminal count), wrap_flag (sticky limit event) out.
module mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0,
  parameter int INIT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_flag
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] r_count, w_limit, w_load, w_step;
  logic             r_flag, w_at;
  always_comb begin
    w_limit = up_dn ? MAX : '0;
    w_at    = r_count == w_limit;
    // compared one bit wider so MODULUS = 2^WIDTH never folds into a constant test
    w_load  = ({1'b0, load_val} >= (WIDTH+1)'(MODULUS)) ? MAX : load_val;
    w_step  = w_at ? ((SATURATE != 0) ? r_count : (up_dn ? '0 : MAX))
                   : (up_dn ? r_count + WIDTH'(1) : r_count - WIDTH'(1));
    tc      = en & ~load & w_at;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= WIDTH'(INIT);
      r_flag  <= 1'b0;
    end else begin
      r_count <= load ? w_load : (en ? w_step : r_count);
      r_flag  <= tc ? 1'b1 : (clr_flag ? 1'b0 : r_flag);
    end
  end
  assign count     = r_count;
  assign wrap_flag = r_flag;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: scoreboard bench for mod_counter (wrap, saturate, load/reset, cascade)
module tb_mod_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst [4];
  logic       en  [4];
  logic       up  [4];
  logic       ld  [4];
  logic       clr [4];
  logic [3:0] lv  [4];
  logic [3:0] cnt [5];
  logic       tc  [5];
  logic       fl  [5];
  typedef struct {
    int         id;
    logic [7:0] cnt;
    logic       tc;
    logic       flag;
    string      nm;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .INIT(0)) u_wrap (
    .clk(clk), .rst(rst[0]), .en(en[0]), .up_dn(up[0]), .load(ld[0]), .load_val(lv[0]),
    .clr_flag(clr[0]), .count(cnt[0]), .tc(tc[0]), .wrap_flag(fl[0]));
  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .INIT(0)) u_sat (
    .clk(clk), .rst(rst[1]), .en(en[1]), .up_dn(up[1]), .load(ld[1]), .load_val(lv[1]),
    .clr_flag(clr[1]), .count(cnt[1]), .tc(tc[1]), .wrap_flag(fl[1]));
  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .INIT(3)) u_init (
    .clk(clk), .rst(rst[2]), .en(en[2]), .up_dn(up[2]), .load(ld[2]), .load_val(lv[2]),
    .clr_flag(clr[2]), .count(cnt[2]), .tc(tc[2]), .wrap_flag(fl[2]));
  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .INIT(0)) u_lo (
    .clk(clk), .rst(rst[3]), .en(en[3]), .up_dn(up[3]), .load(ld[3]), .load_val(lv[3]),
    .clr_flag(clr[3]), .count(cnt[3]), .tc(tc[3]), .wrap_flag(fl[3]));
  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .INIT(0)) u_hi (
    .clk(clk), .rst(rst[3]), .en(tc[3]), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
    .clr_flag(1'b0), .count(cnt[4]), .tc(tc[4]), .wrap_flag(fl[4]));

  // drive one cycle of inputs; optionally expect the outputs seen during that cycle
  task automatic step(input int id, input logic r, e, u, l, input logic [3:0] v,
                      input logic c, input bit chk, input logic [7:0] ec,
                      input logic et, ef, input string nm);
    @(posedge clk);
    #1;
    rst[id] = r; en[id] = e; up[id] = u; ld[id] = l; lv[id] = v; clr[id] = c;
    if (chk) q.push_back('{id, ec, et, ef, nm});
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t x;
      logic [7:0] ac;
      x  = q.pop_front();
      ac = (x.id == 3) ? {cnt[4], cnt[3]} : {4'd0, cnt[x.id]};
      checks += 3;
      if (ac !== x.cnt) begin
        errors++;
        $display("FAIL %s count got %0d want %0d", x.nm, ac, x.cnt);
      end
      if (tc[x.id] !== x.tc) begin
        errors++;
        $display("FAIL %s tc got %b want %b", x.nm, tc[x.id], x.tc);
      end
      if (fl[x.id] !== x.flag) begin
        errors++;
        $display("FAIL %s wrap_flag got %b want %b", x.nm, fl[x.id], x.flag);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b0; en[i] = 1'b0; up[i] = 1'b1; ld[i] = 1'b0; lv[i] = 4'd0; clr[i] = 1'b0;
    end
    // wrap mode, MODULUS 10
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "");
    for (int k = 0; k < 12; k++)
      step(0, 0, 1, 1, 0, 0, 0, 1, 8'(k % 10), k == 9, k >= 10, "wrap_up");
    step(0, 0, 0, 1, 1, 0, 0, 1, 2, 0, 1, "load0");
    step(0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, "down_0");
    step(0, 0, 1, 0, 0, 0, 0, 1, 9, 0, 1, "down_9");
    step(0, 0, 1, 0, 0, 0, 0, 1, 8, 0, 1, "down_8");
    step(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 1, "clr_req");
    step(0, 0, 0, 1, 1, 9, 0, 1, 7, 0, 0, "clr_done");
    step(0, 0, 0, 1, 0, 0, 0, 1, 9, 0, 0, "tc_needs_en");
    step(0, 0, 1, 1, 0, 0, 1, 1, 9, 1, 0, "set_vs_clr");
    step(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, "set_wins");
    // saturate mode, MODULUS 10
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "");
    for (int k = 0; k < 15; k++)
      step(1, 0, 1, 1, 0, 0, 0, 1, 8'((k > 9) ? 9 : k), k >= 9, k >= 10, "sat_up");
    step(1, 0, 0, 1, 1, 0, 0, 1, 9, 0, 1, "sat_load0");
    step(1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, "sat_dn0");
    step(1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, "sat_dn_hold");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "sat_idle");
    // load, clamp, reset priority, direction toggling, INIT 3
    step(2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "");
    step(2, 0, 1, 1, 0, 0, 0, 1, 3, 0, 0, "init_reset");
    step(2, 0, 1, 0, 1, 5, 0, 1, 4, 0, 0, "pre_load5");
    step(2, 0, 1, 1, 1, 12, 0, 1, 5, 0, 0, "load5");
    step(2, 0, 1, 1, 1, 2, 0, 1, 9, 0, 0, "clamp12_tc_masked");
    step(2, 0, 0, 1, 1, 15, 0, 1, 2, 0, 0, "load2");
    step(2, 1, 1, 1, 1, 7, 0, 1, 9, 0, 0, "clamp15");
    step(2, 0, 1, 1, 0, 0, 0, 1, 3, 0, 0, "rst_over_load");
    step(2, 0, 0, 1, 1, 9, 0, 1, 4, 0, 0, "resume");
    step(2, 0, 1, 1, 0, 0, 0, 1, 9, 1, 0, "wrap9");
    step(2, 0, 0, 1, 1, 6, 0, 1, 0, 0, 1, "wrapped");
    step(2, 1, 1, 1, 0, 0, 0, 1, 6, 0, 1, "rst_mid");
    step(2, 0, 1, 1, 0, 0, 0, 1, 3, 0, 0, "rst_done");
    step(2, 0, 1, 1, 0, 0, 0, 1, 4, 0, 0, "tog4");
    step(2, 0, 1, 0, 0, 0, 0, 1, 5, 0, 0, "tog5");
    step(2, 0, 1, 1, 0, 0, 0, 1, 4, 0, 0, "tog4b");
    step(2, 0, 1, 0, 0, 0, 0, 1, 5, 0, 0, "tog5b");
    step(2, 0, 0, 1, 0, 0, 0, 1, 4, 0, 0, "tog_end");
    // two cascaded MODULUS 16 stages
    step(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "");
    for (int k = 0; k < 300; k++)
      step(3, 0, 1, 1, 0, 0, 0, k == 0 || k == 15 || k == 16 || k == 255,
           8'(k), (k % 16) == 15, k >= 16, "cascade");
    step(3, 0, 0, 1, 0, 0, 0, 1, 8'h2C, 0, 1, "cascade300");
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
